// File: rtl/seq_linear_classifier.sv
// seq_linear_classifier: one shared multiply-accumulate stepped over class/feature pairs, tracking a running max/argmax
module seq_linear_classifier #(
  parameter int WIDTH    = 8,
  parameter int FEATURES = 2,
  parameter int C_WIDTH  = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [FEATURES*WIDTH-1:0]              features,
  input  logic [(2**C_WIDTH)*FEATURES*WIDTH-1:0] weights,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [WIDTH-1:0]                       r_value,
  output logic [C_WIDTH-1:0]                     r_class,
  output logic                                   busy
);
  localparam int CLASSES = 2**C_WIDTH;
  localparam int FW = FEATURES > 1 ? $clog2(FEATURES) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(FEATURES-1);
  localparam logic [C_WIDTH-1:0] C_LAST = '1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [FEATURES*WIDTH-1:0] feat_r;
  logic [CLASSES*FEATURES*WIDTH-1:0] w_r;
  logic [FW-1:0] f;
  logic [C_WIDTH-1:0] c, max_idx, best_idx;
  logic [WIDTH-1:0] acc, max_val, prod, sum, best_val;
  logic take;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  // strict compare keeps the lowest class index on ties; class 0 always seeds the max
  always_comb begin
    prod = feat_r[int'(f)*WIDTH +: WIDTH] * w_r[(int'(c)*FEATURES + int'(f))*WIDTH +: WIDTH];
    sum = acc + prod;
    take = c == '0 || sum > max_val;
    best_val = take ? sum : max_val;
    best_idx = take ? c : max_idx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      r_value <= '0;
      r_class <= '0;
      acc <= '0;
      max_val <= '0;
      max_idx <= '0;
      f <= '0;
      c <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          feat_r <= features;
          w_r <= weights;
          acc <= '0;
          max_val <= '0;
          max_idx <= '0;
          f <= '0;
          c <= '0;
          state <= RUN;
        end
        RUN: if (f == F_LAST) begin
          acc <= '0;
          f <= '0;
          c <= c + 1'b1;
          max_val <= best_val;
          max_idx <= best_idx;
          if (c == C_LAST) begin
            r_value <= best_val;
            r_class <= best_idx;
            out_valid <= 1'b1;
            state <= DONE;
          end
        end else begin
          acc <= sum;
          f <= f + 1'b1;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_linear_classifier.sv
// tb_seq_linear_classifier: scoreboard bench, directed vectors on the default build, random vectors on a 4-class/3-feature build
module tb_seq_linear_classifier;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int cyc = 0, errors = 0, checks = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1, a_busy;
  logic [15:0] a_feat = 0;
  logic [31:0] a_w = 0;
  logic [7:0] a_rv;
  logic [0:0] a_rc;
  seq_linear_classifier dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .features(a_feat), .weights(a_w), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .r_value(a_rv), .r_class(a_rc), .busy(a_busy));

  logic b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1, b_busy, b_rand = 0;
  logic [23:0] b_feat = 0;
  logic [95:0] b_w = 0;
  logic [7:0] b_rv;
  logic [1:0] b_rc;
  seq_linear_classifier #(.WIDTH(8), .FEATURES(3), .C_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .features(b_feat), .weights(b_w), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .r_value(b_rv), .r_class(b_rc), .busy(b_busy));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [9:0] model_b(input logic [23:0] fv, input logic [95:0] wv);
    logic [7:0] s, p, best;
    logic [1:0] idx;
    best = 0;
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      s = 0;
      for (int j = 0; j < 3; j++) begin
        p = fv[j*8 +: 8] * wv[(k*3+j)*8 +: 8];
        s = s + p;
      end
      if (k == 0 || s > best) begin
        best = s;
        idx = 2'(k);
      end
    end
    return {idx, best};
  endfunction

  logic [8:0] a_exp_q[$];
  int a_acc_q[$];
  logic [8:0] a_e;
  logic a_prev = 0;
  always @(negedge clk) begin
    if (rst) a_prev = 0;
    else begin
      if (a_in_valid && a_in_ready) a_acc_q.push_back(cyc + 1);
      if (a_out_valid && !a_prev) begin
        check("a_valid_has_accept", a_acc_q.size() > 0, 1);
        if (a_acc_q.size() > 0) check("a_latency", cyc - a_acc_q.pop_front(), 4);
      end
      if (a_out_valid && a_out_ready) begin
        check("a_result_expected", a_exp_q.size() > 0, 1);
        if (a_exp_q.size() > 0) begin
          a_e = a_exp_q.pop_front();
          check("a_r_value", a_rv, a_e[7:0]);
          check("a_r_class", a_rc, a_e[8]);
        end
      end
      a_prev = a_out_valid;
    end
  end

  logic [9:0] b_exp_q[$];
  int b_acc_q[$];
  logic [9:0] b_e;
  logic b_prev = 0;
  always @(negedge clk) begin
    if (rst) b_prev = 0;
    else begin
      if (b_in_valid && b_in_ready) b_acc_q.push_back(cyc + 1);
      if (b_out_valid && !b_prev) begin
        check("b_valid_has_accept", b_acc_q.size() > 0, 1);
        if (b_acc_q.size() > 0) check("b_latency", cyc - b_acc_q.pop_front(), 12);
      end
      if (b_out_valid && b_out_ready) begin
        check("b_result_expected", b_exp_q.size() > 0, 1);
        if (b_exp_q.size() > 0) begin
          b_e = b_exp_q.pop_front();
          check("b_r_value", b_rv, b_e[7:0]);
          check("b_r_class", b_rc, b_e[9:8]);
        end
      end
      b_prev = b_out_valid;
    end
  end

  initial forever begin
    @(posedge clk);
    #1 b_out_ready = b_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send_a(input logic [15:0] fv, input logic [31:0] wv, input logic [8:0] e);
    int t = 0;
    a_feat = fv;
    a_w = wv;
    a_in_valid = 1;
    @(negedge clk);
    while (!a_in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("a_accept", a_in_ready, 1);
    if (a_in_ready) a_exp_q.push_back(e);
    @(posedge clk);
    #1;
    a_in_valid = 0;
    a_feat = ~fv;
    a_w = ~wv;
  endtask

  task automatic drain_a();
    int t = 0;
    while (a_exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("a_drain", a_exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_b(input logic [23:0] fv, input logic [95:0] wv);
    int t = 0;
    b_feat = fv;
    b_w = wv;
    b_in_valid = 1;
    @(negedge clk);
    while (!b_in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("b_accept", b_in_ready, 1);
    if (b_in_ready) b_exp_q.push_back(model_b(fv, wv));
    @(posedge clk);
    #1;
    b_in_valid = 0;
    b_feat = ~fv;
    b_w = ~wv;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_a_in_ready", a_in_ready, 1);
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_r_value", a_rv, 0);
    check("rst_a_r_class", a_rc, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_b_in_ready", b_in_ready, 1);
    check("rst_b_out_valid", b_out_valid, 0);
    @(posedge clk);
    #1;
    send_a({8'd4, 8'd3}, {8'd1, 8'd2, 8'd2, 8'd1}, {1'b0, 8'd11});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("basic_in_ready_low", a_in_ready, 0);
      check("basic_busy", a_busy, 1);
      check("basic_out_valid_timing", a_out_valid, i == 4);
    end
    drain_a();
    send_a({8'd5, 8'd5}, {4{8'd1}}, {1'b0, 8'd10});
    drain_a();
    send_a({8'd16, 8'd16}, {8'd1, 8'd1, 8'd0, 8'd16}, {1'b1, 8'd32});
    drain_a();
    a_out_ready = 0;
    send_a({8'd3, 8'd2}, {8'd0, 8'd3, 8'd1, 8'd1}, {1'b1, 8'd6});
    t = 0;
    @(negedge clk);
    while (!a_out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("bp_valid_seen", a_out_valid, 1);
    @(posedge clk);
    #1;
    a_feat = {8'd1, 8'd7};
    a_w = {8'd2, 8'd0, 8'd0, 8'd1};
    a_in_valid = 1;
    repeat (10) begin
      @(negedge clk);
      check("bp_out_valid", a_out_valid, 1);
      check("bp_r_value", a_rv, 6);
      check("bp_r_class", a_rc, 1);
      check("bp_in_ready", a_in_ready, 0);
    end
    @(posedge clk);
    #1;
    a_out_ready = 1;
    a_exp_q.push_back({1'b0, 8'd7});
    @(negedge clk);
    check("bp_handshake_valid", a_out_valid, 1);
    @(negedge clk);
    check("bp_idle_in_ready", a_in_ready, 1);
    check("bp_idle_out_valid", a_out_valid, 0);
    @(posedge clk);
    #1 a_in_valid = 0;
    @(negedge clk);
    check("bp_new_accepted", a_busy, 1);
    drain_a();
    send_a({8'd9, 8'd9}, {4{8'd3}}, {1'b0, 8'd54});
    @(posedge clk);
    #1 rst = 1;
    a_exp_q.delete();
    a_acc_q.delete();
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("midrun_rst_out_valid", a_out_valid, 0);
    check("midrun_rst_r_value", a_rv, 0);
    check("midrun_rst_r_class", a_rc, 0);
    check("midrun_rst_in_ready", a_in_ready, 1);
    @(posedge clk);
    #1;
    send_a({8'd2, 8'd1}, {8'd3, 8'd1, 8'd2, 8'd2}, {1'b1, 8'd7});
    drain_a();
    b_rand = 1;
    for (int i = 0; i < 1000; i++) send_b(24'($urandom), {$urandom, $urandom, $urandom});
    t = 0;
    while (b_exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("b_drain", b_exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
